lfsr_error_inject: RTL and testbench

//  Streaming error injector between lfsr_source and lfsr_sink, used to prove sink error detection.

---
 rtl/lfsr_error_inject.sv | 119 +++++++++++
 tb/tb_lfsr_error_inject.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_error_inject.sv
// Streaming register slice that XORs a mask into selected beats (periodic or one-shot)
// and counts every corrupted beat, so a sink's error count can be cross-checked.
module lfsr_error_inject #(
    parameter int unsigned DataBits   = 32,
    parameter int unsigned PeriodBits = 16,
    parameter int unsigned CountBits  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_enable,
    input  logic [PeriodBits-1:0] cfg_period,
    input  logic [DataBits-1:0]   cfg_mask,
    input  logic                  cfg_single,
    input  logic                  cfg_clear,
    output logic [CountBits-1:0]  err_count,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DataBits-1:0]   din_data,
    input  logic                  din_eof,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DataBits-1:0]   dout_data,
    output logic                  dout_eof
);

    logic                  accept;
    logic                  periodic_on;
    logic                  periodic_hit;
    logic                  pending_hit;
    logic                  inject;

    logic [PeriodBits-1:0] cnt_q, cnt_d;
    logic                  pending_q, pending_d;
    logic [CountBits-1:0]  err_q, err_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [DataBits-1:0]   dout_data_q, dout_data_d;
    logic                  dout_eof_q, dout_eof_d;

    // Handshake and injection select
    always_comb begin
        din_ready    = !dout_valid_q || dout_ready;
        accept       = din_valid && din_ready;
        periodic_on  = cfg_enable && (cfg_period != '0);
        periodic_hit = accept && periodic_on && (cnt_q == (cfg_period - PeriodBits'(1)));
        pending_hit  = accept && pending_q;
        inject       = periodic_hit || pending_hit;
    end

    // Beat counter: a reduced period is not compared against; cnt runs on and wraps
    always_comb begin
        cnt_d = cnt_q;
        if (!periodic_on) begin
            cnt_d = '0;
        end else if (periodic_hit) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + PeriodBits'(1);
        end
    end

    // A request arriving with an accept applies to the following beat
    always_comb begin
        pending_d = pending_q;
        if (pending_hit) begin
            pending_d = 1'b0;
        end
        if (cfg_single) begin
            pending_d = 1'b1;
        end
    end

    // Saturating injection counter; a clear coinciding with an inject leaves 1
    always_comb begin
        err_d = err_q;
        if (cfg_clear) begin
            err_d = inject ? CountBits'(1) : '0;
        end else if (inject && (err_q != '1)) begin
            err_d = err_q + CountBits'(1);
        end
    end

    // Output register slice
    always_comb begin
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        dout_eof_d   = dout_eof_q;
        if (accept) begin
            dout_valid_d = 1'b1;
            dout_data_d  = din_data ^ (inject ? cfg_mask : '0);
            dout_eof_d   = din_eof;
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            err_q        <= '0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            dout_eof_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            err_q        <= err_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            dout_eof_q   <= dout_eof_d;
        end
    end

    assign err_count  = err_q;
    assign dout_valid = dout_valid_q;
    assign dout_data  = dout_data_q;
    assign dout_eof   = dout_eof_q;

endmodule

// File: tb/tb_lfsr_error_inject.sv
// Scoreboard bench for lfsr_error_inject: a driver pushes expected beats, a monitor pops
// and compares them; a second instance with a 4-bit counter covers saturation.
module tb_lfsr_error_inject;

    logic        clk;
    logic        rst_n;
    logic        cfg_enable;
    logic [15:0] cfg_period;
    logic [31:0] cfg_mask;
    logic        cfg_single;
    logic        cfg_clear;
    logic        din_valid;
    logic [31:0] din_data;
    logic        din_eof;
    logic        dout_ready;

    logic [31:0] err_count;
    logic        din_ready;
    logic        dout_valid;
    logic [31:0] dout_data;
    logic        dout_eof;

    logic [3:0]  err_count4;
    logic        din_ready4;
    logic        dout_valid4;
    logic [31:0] dout_data4;
    logic        dout_eof4;

    lfsr_error_inject #(.DataBits(32), .PeriodBits(16), .CountBits(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_period(cfg_period),
        .cfg_mask(cfg_mask), .cfg_single(cfg_single), .cfg_clear(cfg_clear),
        .err_count(err_count), .din_valid(din_valid), .din_ready(din_ready),
        .din_data(din_data), .din_eof(din_eof), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_data(dout_data), .dout_eof(dout_eof)
    );

    lfsr_error_inject #(.DataBits(32), .PeriodBits(16), .CountBits(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_period(cfg_period),
        .cfg_mask(cfg_mask), .cfg_single(cfg_single), .cfg_clear(cfg_clear),
        .err_count(err_count4), .din_valid(din_valid), .din_ready(din_ready4),
        .din_data(din_data), .din_eof(din_eof), .dout_valid(dout_valid4),
        .dout_ready(dout_ready), .dout_data(dout_data4), .dout_eof(dout_eof4)
    );

    typedef struct {
        logic [31:0] d;
        logic        eof;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_popped = 0;
    int          cyc      = 0;
    logic        mon_en   = 1'b1;
    logic        bp_en    = 1'b0;
    logic [31:0] bp_pat   = 32'b1011_0010_1110_0101_0011_1000_1101_0110;
    logic [31:0] lfsr     = 32'h1ACE_B00C;
    int          acc_idx  = 0;
    logic        pend_m   = 1'b0;
    int          err_exp  = 0;
    int          err_exp4 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Downstream ready: held high, or a fixed rotating stall pattern
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            dout_ready = bp_pat[0];
            bp_pat     = {bp_pat[0], bp_pat[31:1]};
        end else begin
            dout_ready = 1'b1;
        end
    end

    // Monitor: compare each presented beat against the scoreboard head
    initial begin
        logic prev_stall;
        exp_t h;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_stall = 1'b0;
            end else if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    h = exp_q[0];
                    check(prev_stall ? "stall_hold" : "beat_data",
                          64'({dout_data, dout_eof}), 64'({h.d, h.eof}));
                    check("beat_data_cnt4", 64'({dout_valid4, dout_data4, dout_eof4}),
                          64'({1'b1, h.d, h.eof}));
                    if (!prev_stall) check("latency", 64'(cyc - h.cyc), 64'(1));
                    if (dout_ready) begin
                        void'(exp_q.pop_front());
                        n_popped++;
                    end
                end
                prev_stall = !dout_ready;
            end else begin
                if (prev_stall) check("valid_dropped", 64'(0), 64'(1));
                prev_stall = 1'b0;
            end
        end
    end

    task automatic set_cfg(input logic en, input logic [15:0] period, input logic [31:0] mask);
        cfg_enable = 1'b0;
        @(posedge clk); #1;
        cfg_enable = en;
        cfg_period = period;
        cfg_mask   = mask;
        acc_idx    = 0;
    endtask

    task automatic pulse_clear();
        cfg_clear = 1'b1;
        @(posedge clk); #1;
        cfg_clear = 1'b0;
        err_exp   = 0;
        err_exp4  = 0;
    endtask

    // Drive n beats; single_beat/clear_beat pulse cfg_single/cfg_clear with that beat (0 = none)
    task automatic stream(input int n, input int single_beat, input int clear_beat);
        int   start_pop;
        logic acc;
        logic per;
        logic inj;
        start_pop = n_popped;
        for (int i = 0; i < n; i++) begin
            din_valid  = 1'b1;
            din_data   = lfsr;
            din_eof    = (i == n - 1);
            cfg_single = (i + 1 == single_beat);
            cfg_clear  = (i + 1 == clear_beat);
            acc = 1'b0;
            for (int w = 0; w < 200; w++) begin
                @(negedge clk);
                if (din_ready && din_ready4) begin
                    acc = 1'b1;
                    break;
                end
            end
            if (!acc) begin
                check("accept_timeout", 64'(0), 64'(1));
                break;
            end
            acc_idx++;
            per = cfg_enable && (cfg_period != 0) && ((acc_idx % int'(cfg_period)) == 0);
            inj = per || pend_m;
            if (inj) pend_m = 1'b0;
            if (cfg_single) pend_m = 1'b1;
            if (cfg_clear) begin
                err_exp  = inj ? 1 : 0;
                err_exp4 = inj ? 1 : 0;
            end else if (inj) begin
                err_exp++;
                if (err_exp4 < 15) err_exp4++;
            end
            exp_q.push_back('{d: din_data ^ (inj ? cfg_mask : 32'h0), eof: din_eof, cyc: cyc});
            @(posedge clk); #1;
            lfsr = {lfsr[30:0], 1'b0} ^ (lfsr[31] ? 32'h0040_0007 : 32'h0);
        end
        din_valid  = 1'b0;
        din_eof    = 1'b0;
        cfg_single = 1'b0;
        cfg_clear  = 1'b0;
        for (int w = 0; w < 500; w++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 64'(exp_q.size()), 64'(0));
        check("beat_count", 64'(n_popped - start_pop), 64'(n));
        @(posedge clk); #1;
        check("err_count", 64'(err_count), 64'(err_exp));
        check("err_count4", 64'(err_count4), 64'(err_exp4));
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_enable = 1'b0;
        cfg_period = 16'd0;
        cfg_mask   = 32'h0;
        cfg_single = 1'b0;
        cfg_clear  = 1'b0;
        din_valid  = 1'b0;
        din_data   = 32'h0;
        din_eof    = 1'b0;
        dout_ready = 1'b1;

        #2;
        check("rst_dout_valid", 64'(dout_valid), 64'(0));
        check("rst_dout_data", 64'({dout_data, dout_eof}), 64'(0));
        check("rst_err_count", 64'(err_count), 64'(0));
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Pass-through with injection disabled
        set_cfg(1'b0, 16'd8, 32'hFFFF_FFFF);
        stream(100, 0, 0);

        // Periodic: beats 8,16,...,64 corrupted
        set_cfg(1'b1, 16'd8, 32'h8C00_0023);
        stream(64, 0, 0);

        // Backpressure with every third beat corrupted
        set_cfg(1'b1, 16'd3, 32'hFFFF_0000);
        bp_en = 1'b1;
        stream(60, 0, 0);
        bp_en = 1'b0;
        @(posedge clk); #1;

        // One-shot requested with beat 3, lands on beat 4 together with the periodic hit
        pulse_clear();
        set_cfg(1'b1, 16'd4, 32'h0000_00FF);
        stream(6, 3, 0);
        // One-shot alone, periodic off
        set_cfg(1'b1, 16'd0, 32'h5A5A_5A5A);
        stream(4, 2, 0);

        // Saturation of the 4-bit counter, then clear coinciding with an inject
        pulse_clear();
        set_cfg(1'b1, 16'd1, 32'h0000_0001);
        stream(20, 0, 0);
        stream(3, 0, 3);

        // Reset asserted mid-stream drops the in-flight beat asynchronously
        mon_en = 1'b0;
        set_cfg(1'b1, 16'd1, 32'hC0DE_0000);
        din_valid = 1'b1;
        din_data  = 32'h1234_5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'({dout_valid, dout_valid4}), 64'(0));
        check("async_rst_err", 64'({err_count, err_count4}), 64'(0));
        check("async_rst_data", 64'({dout_data, dout_eof}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_idle", 64'(dout_valid), 64'(0));
        @(negedge clk);
        check("post_rst_first_beat", 64'({dout_valid, dout_data}), 64'({1'b1, 32'h1234_5678 ^ 32'hC0DE_0000}));
        check("post_rst_err", 64'(err_count), 64'(1));
        din_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
